mem_cmd_issuer: RTL and testbench

MEM_CMD_ISSUER -- requirements
Module: mem_cmd_issuer

---
 rtl/mem_pkg.sv | 28 ++
 rtl/open_row_table.sv | 39 +++
 rtl/mem_cmd_issuer.sv | 173 +++++++++++++++++
 tb/tb_mem_cmd_issuer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and timing defaults for the DDR4 command issuer.
// Holds the command encoding, FSM state type and default timing values.
package mem_pkg;
   localparam int ADDRWIDTH_D = 17;
   localparam int COLWIDTH_D  = 10;
   localparam int BGWIDTH_D   = 2;
   localparam int BAWIDTH_D   = 2;
   localparam int BL_D        = 8;
   localparam int TRP_D       = 4;
   localparam int TRCD_D      = 4;
   localparam int TCL_D       = 5;
   localparam int TCWL_D      = 4;

   // Opcode carried on A[top:top-2] for non-activate commands.
   localparam logic [2:0] OP_RD  = 3'b101;
   localparam logic [2:0] OP_WR  = 3'b100;
   localparam logic [2:0] OP_PRE = 3'b010;

   typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE} cmd_e;

   typedef enum logic [2:0] {
      IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_LAT, BURST
   } state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/open_row_table.sv
// Per-bank open-row tracker: one valid bit and row address per bank.
// Lookup is combinational; set (ACT) and clear (PRE) land on the clock edge.
module open_row_table #(
   parameter int IDXW = 4,
   parameter int ROWW = 17
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [IDXW-1:0] lookup_idx,
   output logic            lookup_valid,
   output logic [ROWW-1:0] lookup_row,
   input  logic            set_en,
   input  logic [IDXW-1:0] set_idx,
   input  logic [ROWW-1:0] set_row,
   input  logic            clr_en,
   input  logic [IDXW-1:0] clr_idx
);
   localparam int NBANKS = 1 << IDXW;

   logic [NBANKS-1:0] vld;
   logic [ROWW-1:0]   rows [NBANKS];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld <= '0;
      end else begin
         if (clr_en) vld[clr_idx] <= 1'b0;
         if (set_en) vld[set_idx] <= 1'b1;
      end
   end

   // Row storage needs no reset; it is only trusted behind its valid bit.
   always_ff @(posedge clk) begin
      if (set_en) rows[set_idx] <= set_row;
   end

   assign lookup_valid = vld[lookup_idx];
   assign lookup_row   = rows[lookup_idx];
endmodule

// File: rtl/mem_cmd_issuer.sv
// Single-rank DDR4 command issuer: one request in flight, open-page policy,
// PRE/ACT/CAS sequencing with fixed timing and a DQ window per burst.
module mem_cmd_issuer
   import mem_pkg::*;
#(
   parameter int ADDRWIDTH = ADDRWIDTH_D,
   parameter int COLWIDTH  = COLWIDTH_D,
   parameter int BGWIDTH   = BGWIDTH_D,
   parameter int BAWIDTH   = BAWIDTH_D,
   parameter int BL        = BL_D,
   parameter int TRP       = TRP_D,
   parameter int TRCD      = TRCD_D,
   parameter int TCL       = TCL_D,
   parameter int TCWL      = TCWL_D
) (
   input  logic                                            clk,
   input  logic                                            reset_n,
   input  logic                                            req_valid,
   output logic                                            req_ready,
   input  logic                                            req_wr,
   input  logic [BGWIDTH+BAWIDTH+ADDRWIDTH+COLWIDTH-1:0]   req_addr,
   input  logic                                            stall,
   output logic                                            cke,
   output logic                                            cs_n,
   output logic                                            act_n,
   output logic [ADDRWIDTH-1:0]                            A,
   output logic [BGWIDTH-1:0]                              bg,
   output logic [BAWIDTH-1:0]                              ba,
   output logic                                            rd_window,
   output logic                                            wr_window,
   output logic                                            rsp_valid
);
   localparam int IDXW = BGWIDTH + BAWIDTH;
   localparam int REQW = IDXW + ADDRWIDTH + COLWIDTH;
   localparam int TMAX = max2(max2(max2(TRP, TRCD), max2(TCL, TCWL)), BL);
   localparam int CNTW = $clog2(TMAX) + 1;

   state_e              state;
   logic                wr_q;
   logic [REQW-1:0]     addr_q;
   logic [CNTW-1:0]     cnt;
   logic [CNTW-1:0]     lat;
   logic                lk_valid, hit, issue;
   logic [ADDRWIDTH-1:0] lk_row;
   cmd_e                cmd;

   wire [IDXW-1:0]      req_idx = req_addr[REQW-1 -: IDXW];
   wire [ADDRWIDTH-1:0] req_row = req_addr[COLWIDTH +: ADDRWIDTH];
   wire [IDXW-1:0]      idx_q   = addr_q[REQW-1 -: IDXW];
   wire [ADDRWIDTH-1:0] row_q   = addr_q[COLWIDTH +: ADDRWIDTH];
   wire [COLWIDTH-1:0]  col_q   = addr_q[COLWIDTH-1:0];

   open_row_table #(.IDXW(IDXW), .ROWW(ADDRWIDTH)) u_tbl (
      .clk          (clk),
      .reset_n      (reset_n),
      .lookup_idx   (req_idx),
      .lookup_valid (lk_valid),
      .lookup_row   (lk_row),
      .set_en       (cmd == CMD_ACT),
      .set_idx      (idx_q),
      .set_row      (row_q),
      .clr_en       (cmd == CMD_PRE),
      .clr_idx      (idx_q)
   );

   assign hit       = lk_valid && (lk_row == req_row);
   assign req_ready = cke && (state == IDLE) && !stall;
   assign lat       = wr_q ? CNTW'(TCWL) : CNTW'(TCL);

   // Command pins decode the current state so a stall defers the command in
   // the very cycle it is raised; wait timers have already expired by then.
   assign issue = !stall && (state == PRE || state == ACT || state == CAS);

   always_comb begin
      cmd = CMD_NOP;
      if (issue) begin
         case (state)
            PRE:     cmd = CMD_PRE;
            ACT:     cmd = CMD_ACT;
            default: cmd = wr_q ? CMD_WR : CMD_RD;
         endcase
      end
   end

   always_comb begin
      cs_n  = 1'b1;
      act_n = 1'b1;
      A     = '0;
      bg    = '0;
      ba    = '0;
      if (cmd != CMD_NOP) begin
         cs_n = 1'b0;
         {bg, ba} = idx_q;
         case (cmd)
            CMD_ACT: begin
               act_n = 1'b0;
               A     = row_q;
            end
            CMD_PRE: A[ADDRWIDTH-1 -: 3] = OP_PRE;
            CMD_RD: begin
               A[ADDRWIDTH-1 -: 3] = OP_RD;
               A[COLWIDTH-1:0]     = col_q;
            end
            CMD_WR: begin
               A[ADDRWIDTH-1 -: 3] = OP_WR;
               A[COLWIDTH-1:0]     = col_q;
            end
            default: ;
         endcase
      end
   end

   assign rd_window = (state == BURST) && !wr_q;
   assign wr_window = (state == BURST) && wr_q;
   assign rsp_valid = (state == BURST) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         cke    <= 1'b0;
         cnt    <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         cke <= 1'b1;
         case (state)
            IDLE: if (req_valid && req_ready) begin
               wr_q   <= req_wr;
               addr_q <= req_addr;
               state  <= hit ? CAS : (lk_valid ? PRE : ACT);
            end
            PRE: if (issue) begin
               cnt   <= CNTW'(TRP - 1);
               state <= (TRP == 1) ? ACT : WAIT_RP;
            end
            WAIT_RP: begin
               cnt <= cnt - CNTW'(1);
               if (cnt == CNTW'(1)) state <= ACT;
            end
            ACT: if (issue) begin
               cnt   <= CNTW'(TRCD - 1);
               state <= (TRCD == 1) ? CAS : WAIT_RCD;
            end
            WAIT_RCD: begin
               cnt <= cnt - CNTW'(1);
               if (cnt == CNTW'(1)) state <= CAS;
            end
            CAS: if (issue) begin
               if (lat == CNTW'(1)) begin
                  cnt   <= CNTW'(BL - 1);
                  state <= BURST;
               end else begin
                  cnt   <= lat - CNTW'(1);
                  state <= WAIT_LAT;
               end
            end
            WAIT_LAT: begin
               if (cnt == CNTW'(1)) begin
                  cnt   <= CNTW'(BL - 1);
                  state <= BURST;
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end
            BURST: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - CNTW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Scoreboard bench for mem_cmd_issuer: directed requests push expected pin
// events (cycle-stamped), a negedge monitor pops and compares them.
module tb_mem_cmd_issuer;
   localparam int K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_RSP = 5;
   localparam int K_RWON = 6, K_RWOFF = 7, K_WWON = 8, K_WWOFF = 9, K_BAD = 10;

   typedef struct {
      int cyc;
      int kind;
      int a;
      int g;
      int b;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [30:0] req_addr = '0;
   logic        stall = 1'b0;
   logic        cke, cs_n, act_n;
   logic [16:0] A;
   logic [1:0]  bg, ba;
   logic        rd_window, wr_window, rsp_valid;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b0;
   logic prw = 1'b0, pww = 1'b0;
   ev_t  exp_q[$];

   mem_cmd_issuer dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .stall(stall), .cke(cke), .cs_n(cs_n),
      .act_n(act_n), .A(A), .bg(bg), .ba(ba), .rd_window(rd_window),
      .wr_window(wr_window), .rsp_valid(rsp_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input int k, input int a, input int g, input int b);
      ev_t e;
      e.cyc = c; e.kind = k; e.a = a; e.g = g; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic seen(input int k, input int a, input int g, input int b);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: kind %0d A=%0h at cycle %0d, none expected", k, a, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || (e.a >= 0 && e.a != a) ||
             (e.g >= 0 && e.g != g) || (e.b >= 0 && e.b != b)) begin
            miscompares++;
            $display("FAIL event: got kind %0d cyc %0d A=%0h bg=%0d ba=%0d, expected kind %0d cyc %0d A=%0h bg=%0d ba=%0d",
                     k, cyc, a, g, b, e.kind, e.cyc, e.a, e.g, e.b);
         end
      end
   endtask

   // Events within one cycle are reported in a fixed order: command, window edges, response.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!cs_n) begin
            if (!act_n)              seen(K_ACT, int'(A), int'(bg), int'(ba));
            else if (A[16:14] == 3'b101) seen(K_RD, int'(A), int'(bg), int'(ba));
            else if (A[16:14] == 3'b100) seen(K_WR, int'(A), int'(bg), int'(ba));
            else if (A[16:14] == 3'b010) seen(K_PRE, int'(A), int'(bg), int'(ba));
            else                     seen(K_BAD, int'(A), int'(bg), int'(ba));
         end
         if (rd_window && !prw) seen(K_RWON, -1, -1, -1);
         if (!rd_window && prw) seen(K_RWOFF, -1, -1, -1);
         if (wr_window && !pww) seen(K_WWON, -1, -1, -1);
         if (!wr_window && pww) seen(K_WWOFF, -1, -1, -1);
         if (rsp_valid)         seen(K_RSP, -1, -1, -1);
         prw = rd_window;
         pww = wr_window;
      end
   end

   task automatic issue(input logic wr, input int g, input int b, input int row,
                        input int col, output int t);
      @(posedge clk); #1;
      req_wr    = wr;
      req_addr  = {g[1:0], b[1:0], row[16:0], col[9:0]};
      req_valid = 1'b1;
      #1;
      t = -1;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin
            t = cyc;
            break;
         end
         @(posedge clk); #2;
      end
      if (t < 0) begin
         miscompares++;
         $display("FAIL accept_timeout: req_ready never rose");
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d expected events still pending", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cke", cke, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_act_n", act_n, 1);
      chk("rst_A", int'(A), 0);
      chk("rst_bgba", int'({bg, ba}), 0);
      chk("rst_windows", int'({rd_window, wr_window}), 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_ready", req_ready, 0);
      mon_en  = 1'b1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("cke_rise", cke, 1);
      chk("ready_idle", req_ready, 1);

      // Closed bank read.
      issue(1'b0, 1, 2, 'h155, 'h20, t);
      push(t+1, K_ACT, 'h155, 1, 2);
      push(t+5, K_RD, 'h14020, 1, 2);
      push(t+10, K_RWON, -1, -1, -1);
      push(t+17, K_RSP, -1, -1, -1);
      push(t+18, K_RWOFF, -1, -1, -1);
      drain();

      // Row hit.
      issue(1'b0, 1, 2, 'h155, 'h20, t);
      push(t+1, K_RD, 'h14020, 1, 2);
      push(t+6, K_RWON, -1, -1, -1);
      push(t+13, K_RSP, -1, -1, -1);
      push(t+14, K_RWOFF, -1, -1, -1);
      drain();

      // Row conflict write.
      issue(1'b1, 1, 2, 'h0AA, 'h20, t);
      push(t+1, K_PRE, 'h08000, 1, 2);
      push(t+5, K_ACT, 'h0AA, 1, 2);
      push(t+9, K_WR, 'h10020, 1, 2);
      push(t+13, K_WWON, -1, -1, -1);
      push(t+20, K_RSP, -1, -1, -1);
      push(t+21, K_WWOFF, -1, -1, -1);
      drain();

      // New row 0x0AA now open: read is a hit.
      issue(1'b0, 1, 2, 'h0AA, 'h5, t);
      push(t+1, K_RD, 'h14005, 1, 2);
      push(t+6, K_RWON, -1, -1, -1);
      push(t+13, K_RSP, -1, -1, -1);
      push(t+14, K_RWOFF, -1, -1, -1);
      drain();

      // Stall in IDLE blocks acceptance.
      @(posedge clk); #1;
      stall = 1'b1; req_valid = 1'b1; req_wr = 1'b0;
      #1;
      chk("ready_stall_idle", req_ready, 0);
      @(posedge clk); #1;
      stall = 1'b0; req_valid = 1'b0;

      // Stall on closed-bank read defers ACT, max row/col.
      issue(1'b0, 0, 0, 'h1FFFF, 'h3FF, t);
      stall = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         #1;
         chk("ready_stall_busy", req_ready, 0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      push(t+7, K_ACT, 'h1FFFF, 0, 0);
      push(t+11, K_RD, 'h143FF, 0, 0);
      push(t+16, K_RWON, -1, -1, -1);
      push(t+23, K_RSP, -1, -1, -1);
      push(t+24, K_RWOFF, -1, -1, -1);
      drain();

      // Reset in the middle of a burst.
      issue(1'b0, 3, 3, 0, 0, t);
      push(t+1, K_ACT, 0, 3, 3);
      push(t+5, K_RD, 'h14000, 3, 3);
      push(t+10, K_RWON, -1, -1, -1);
      push(t+13, K_RWOFF, -1, -1, -1);
      repeat (11) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("midrst_cke", cke, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_window", rd_window, 0);
      @(posedge clk); #1;
      chk("midrst_cke_rise", cke, 1);
      drain();

      // Table was cleared: same row needs ACT again.
      issue(1'b0, 3, 3, 0, 0, t);
      push(t+1, K_ACT, 0, 3, 3);
      push(t+5, K_RD, 'h14000, 3, 3);
      push(t+10, K_RWON, -1, -1, -1);
      push(t+17, K_RSP, -1, -1, -1);
      push(t+18, K_RWOFF, -1, -1, -1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
